freq_meas_9bit: RTL and testbench

Receive-side companion to the 9-bit loadable frequency divider in the digital-modulation chain. The block measures the half-period of an incoming square wave in `clk` cycles and recovers the 9-bit load value that produced it: `cnt_est = 512 − half_period`. It also gives a binary FSK bit decision against a threshold, which makes it the demodulator front end for divider-generated FSK.

---
 rtl/freq_mod_pkg.sv | 15 +
 rtl/sig_sync_edge.sv | 28 ++
 rtl/freq_meas_9bit.sv | 122 ++++++++++++
 tb/tb_freq_meas_9bit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/freq_mod_pkg.sv
// Constants and state type shared by the frequency divider and the
// frequency measurement blocks of the modulation chain.
package freq_mod_pkg;

   localparam int CNT_W      = 9;
   localparam int LEN_W      = CNT_W + 1;
   localparam int FULL_COUNT = 512;

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      MEAS
   } meas_state_t;

endpackage

// File: rtl/sig_sync_edge.sv
// Two-flop synchronizer plus one delay stage for an asynchronous level.
// Flags every transition (both polarities) with a one-cycle edge_o pulse.
module sig_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic async_i,
   output logic level_o,
   output logic edge_o
);

   logic s1_q, s2_q, s3_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= async_i;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign level_o = s2_q;
   assign edge_o  = s2_q ^ s3_q;

endmodule

// File: rtl/freq_meas_9bit.sv
// Measures the half-period of sig_in in clk cycles and recovers the divider
// load value (512 - half_period), with an FSK bit decision against THRESH.
module freq_meas_9bit
   import freq_mod_pkg::*;
#(
   parameter logic [CNT_W-1:0] THRESH   = 9'd256,
   parameter int               MIN_HALF = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             sig_in,
   output logic [CNT_W-1:0] cnt_est,
   output logic             bit_out,
   output logic             est_valid,
   output logic             glitch,
   output logic             lost
);

   localparam logic [LEN_W-1:0] MIN_L  = LEN_W'(MIN_HALF);
   localparam logic [LEN_W-1:0] FULL_L = LEN_W'(FULL_COUNT);

   meas_state_t      state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] est_val;
   logic             bit_q, bit_d;
   logic             ev_q, ev_d;
   logic             gl_q, gl_d;
   logic             lo_q, lo_d;
   logic             sig_edge;
   logic             sig_level_unused;

   // The synchronized level itself is not needed here; only transitions are.
   sig_sync_edge u_sync (
      .clk     (clk),
      .rst     (rst),
      .async_i (sig_in),
      .level_o (sig_level_unused),
      .edge_o  (sig_edge)
   );

   // 512 - N fits 9 bits exactly for 1 <= N <= 512 (N = 512 wraps to 0).
   assign est_val = CNT_W'(FULL_L - len_q);

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      ev_d    = 1'b0;
      gl_d    = 1'b0;
      lo_d    = 1'b0;
      if (!en) begin
         state_d = IDLE;
         len_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = ARM;
               len_d   = '0;
            end
            ARM: begin
               if (sig_edge) begin
                  len_d   = LEN_W'(1);
                  state_d = MEAS;
               end
            end
            MEAS: begin
               // An edge on the cycle len reaches 512 wins over the timeout.
               if (sig_edge) begin
                  len_d = LEN_W'(1);
                  if (len_q < MIN_L) begin
                     gl_d = 1'b1;
                  end else begin
                     cnt_d = est_val;
                     bit_d = (est_val >= THRESH);
                     ev_d  = 1'b1;
                  end
               end else if (len_q == FULL_L) begin
                  lo_d    = 1'b1;
                  len_d   = '0;
                  state_d = ARM;
               end else begin
                  len_d = len_q + LEN_W'(1);
               end
            end
            default: begin
               state_d = IDLE;
               len_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         len_q   <= '0;
         cnt_q   <= '0;
         bit_q   <= 1'b0;
         ev_q    <= 1'b0;
         gl_q    <= 1'b0;
         lo_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         ev_q    <= ev_d;
         gl_q    <= gl_d;
         lo_q    <= lo_d;
      end
   end

   assign cnt_est   = cnt_q;
   assign bit_out   = bit_q;
   assign est_valid = ev_q;
   assign glitch    = gl_q;
   assign lost      = lo_q;

endmodule

// File: tb/tb_freq_meas_9bit.sv
// Scoreboard bench for freq_meas_9bit: two instances (MIN_HALF 1 and 4)
// share one stimulus; expected events are derived from sig_in toggle spacing.
module tb_freq_meas_9bit;

   localparam int K_EST  = 0;
   localparam int K_GLI  = 1;
   localparam int K_LOST = 2;
   localparam int MIN0   = 1;
   localparam int MIN1   = 4;

   typedef struct {
      int kind;
      int val;
      bit chk;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       en;
   logic       sig_in;
   logic [8:0] cnt_est0, cnt_est1;
   logic       bit_out0, bit_out1;
   logic       est_valid0, est_valid1;
   logic       glitch0, glitch1;
   logic       lost0, lost1;

   exp_t q0[$];
   exp_t q1[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   int   gap = 0;
   bit   meas = 0;
   bit   last_pulse = 0;
   int   last_est[2];
   int   last_pulse_cyc[2];

   freq_meas_9bit #(.THRESH(9'd256), .MIN_HALF(MIN0)) dut0 (
      .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
      .cnt_est(cnt_est0), .bit_out(bit_out0), .est_valid(est_valid0),
      .glitch(glitch0), .lost(lost0)
   );

   freq_meas_9bit #(.THRESH(9'd256), .MIN_HALF(MIN1)) dut1 (
      .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
      .cnt_est(cnt_est1), .bit_out(bit_out1), .est_valid(est_valid1),
      .glitch(glitch1), .lost(lost1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic push(input int id, input exp_t e);
      if (id == 0) q0.push_back(e);
      else         q1.push_back(e);
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      gap++;
      if (meas && gap == 513) begin
         e.kind = K_LOST;
         e.val  = 0;
         e.chk  = last_pulse;
         push(0, e);
         push(1, e);
         meas = 0;
      end
   endtask

   task automatic toggle();
      exp_t e;
      sig_in = ~sig_in;
      if (en && meas) begin
         e.val  = 512 - gap;
         e.chk  = 0;
         e.kind = (gap < MIN0) ? K_GLI : K_EST;
         push(0, e);
         e.kind = (gap < MIN1) ? K_GLI : K_EST;
         push(1, e);
         last_pulse = 1;
      end else if (en) begin
         meas       = 1;
         last_pulse = 0;
      end
      gap = 0;
   endtask

   task automatic half(input int h);
      repeat (h) tick();
      toggle();
   endtask

   task automatic mon(input int id, input logic ev, input logic gl, input logic lo,
                      input logic [8:0] ce, input logic bo);
      exp_t e;
      int   kind;
      bit   have;
      if (!(ev | gl | lo)) return;
      check($sformatf("pulse_excl%0d", id), 32'(ev) + 32'(gl) + 32'(lo), 1);
      kind = ev ? K_EST : (gl ? K_GLI : K_LOST);
      have = 0;
      if (id == 0 && q0.size() > 0) begin
         e = q0.pop_front();
         have = 1;
      end else if (id == 1 && q1.size() > 0) begin
         e = q1.pop_front();
         have = 1;
      end
      if (!have) begin
         check($sformatf("unexpected_pulse%0d", id), kind, 99);
         return;
      end
      $display("[%0d] inst%0d kind=%0d cnt_est=%0d bit_out=%0d (exp kind=%0d val=%0d)",
               cyc, id, kind, ce, bo, e.kind, e.val);
      check($sformatf("kind%0d", id), kind, e.kind);
      if (e.kind == K_EST) begin
         check($sformatf("cnt_est%0d", id), ce, e.val);
         check($sformatf("bit_out%0d", id), bo, (e.val >= 256) ? 1 : 0);
         last_est[id] = e.val;
      end else begin
         check($sformatf("cnt_hold%0d", id), ce, last_est[id]);
      end
      if (kind == K_LOST && e.chk)
         check($sformatf("lost_delay%0d", id), cyc - last_pulse_cyc[id], 512);
      if (kind != K_LOST) last_pulse_cyc[id] = cyc;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         mon(0, est_valid0, glitch0, lost0, cnt_est0, bit_out0);
         mon(1, est_valid1, glitch1, lost1, cnt_est1, bit_out1);
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      en = 1'b0;
      sig_in = 1'b0;
      last_est = '{0, 0};
      last_pulse_cyc = '{0, 0};
      repeat (3) @(posedge clk);
      #1;
      check("rst_cnt_est0", cnt_est0, 0);
      check("rst_bit_out0", bit_out0, 0);
      check("rst_est_valid0", est_valid0, 0);
      check("rst_glitch0", glitch0, 0);
      check("rst_lost0", lost0, 0);
      check("rst_cnt_est1", cnt_est1, 0);
      rst = 1'b0;
      en = 1'b1;
      repeat (4) tick();

      // steady tone, load 300; first toggle only arms
      toggle();
      repeat (5) half(212);

      // FSK switch 300 -> 100
      repeat (4) half(212);
      repeat (4) half(412);

      // extremes: load 0 then load 511, back to 300
      repeat (3) half(512);
      repeat (12) half(1);
      repeat (2) half(212);

      // 2-cycle pulse injected right after a regular edge
      half(2);
      half(2);
      half(208);
      repeat (2) half(212);

      // timeout: no edge for 600 cycles, then re-arm
      repeat (600) tick();
      toggle();
      repeat (2) half(212);

      // enable dropped mid-measurement
      repeat (100) tick();
      en = 1'b0;
      meas = 0;
      repeat (50) tick();
      check("en_hold_cnt0", cnt_est0, last_est[0]);
      check("en_hold_cnt1", cnt_est1, last_est[1]);
      en = 1'b1;
      repeat (4) tick();
      toggle();
      repeat (2) half(212);

      // reset 100 cycles into a half-period
      repeat (100) tick();
      check("pre_rst_q0_empty", q0.size(), 0);
      check("pre_rst_q1_empty", q1.size(), 0);
      rst = 1'b1;
      #1;
      check("mid_rst_cnt_est0", cnt_est0, 0);
      check("mid_rst_bit_out0", bit_out0, 0);
      check("mid_rst_cnt_est1", cnt_est1, 0);
      check("mid_rst_bit_out1", bit_out1, 0);
      sig_in = 1'b0;
      meas = 0;
      last_est = '{0, 0};
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      gap = 0;
      repeat (4) tick();
      toggle();
      repeat (3) half(412);

      repeat (10) tick();
      check("final_q0_empty", q0.size(), 0);
      check("final_q1_empty", q1.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
